// File: rtl/cpu_types_pkg.sv
// Shared pipeline types for the MIPS core, including the memory-stage FSM states
// and the word-address helper used for LL/SC link and snoop comparisons.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } memstate_t;

    localparam int WORD_ADDR_LSB = 2;

    // Byte offsets are ignored: two addresses alias when they name the same word.
    function automatic logic word_match(input word_t a, input word_t b);
        return a[31:WORD_ADDR_LSB] == b[31:WORD_ADDR_LSB];
    endfunction

endpackage

// File: rtl/link_reg.sv
// LL/SC link register: one reservation (valid bit + address); any clear source
// overrides a simultaneous set, including a snoop hitting the address being linked.
import cpu_types_pkg::*;

module link_reg (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        set,
    input  logic [31:0] set_addr,
    input  logic        clear,
    input  logic        ccinv,
    input  logic [31:0] ccsnoopaddr,
    input  logic [31:0] cmp_addr,
    output logic        link_valid,
    output logic        match
);

    logic [31:0] link_addr;
    logic        snoop_hit;
    logic        kill;

    assign snoop_hit = ccinv & (word_match(ccsnoopaddr, link_addr) |
                                (set & word_match(ccsnoopaddr, set_addr)));
    assign kill      = clear | snoop_hit;
    assign match     = word_match(link_addr, cmp_addr);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            link_valid <= 1'b0;
            link_addr  <= '0;
        end else begin
            if (set) begin
                link_addr <= set_addr;
            end
            if (kill) begin
                link_valid <= 1'b0;
            end else if (set) begin
                link_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: issues data-cache requests, stalls upstream until dhit, resolves
// LL/SC against the link register and flags requests stuck longer than TIMEOUT.
import cpu_types_pkg::*;

module mem_stage #(
    parameter int TIMEOUT = 255,
    parameter int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        valid_in,
    input  logic        memread_in,
    input  logic        memwrite_in,
    input  logic        datomic_in,
    input  logic [31:0] aluResult_in,
    input  logic [31:0] storeData_in,
    input  logic        regwrite_in,
    input  logic [1:0]  memtoreg_in,
    input  logic [4:0]  branchDest_in,
    input  logic [31:0] npc_in,
    input  logic [31:0] upper16_in,
    input  logic        dhit,
    input  logic [31:0] dmemload,
    input  logic        ccinv,
    input  logic [31:0] ccsnoopaddr,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemstore,
    output logic        stall_out,
    output logic        regwrite_out,
    output logic [1:0]  memtoreg_out,
    output logic [4:0]  branchDest_out,
    output logic [31:0] npc_out,
    output logic [31:0] aluResult_out,
    output logic [31:0] upper16_out,
    output logic [31:0] dMemLoad_out,
    output logic        mem_timeout
);

    localparam logic [CW-1:0] WD_MAX = CW'(TIMEOUT);

    memstate_t     state, next_state;
    logic [CW-1:0] wd_cnt, wd_next;
    logic          link_valid, link_match;
    logic          sc_fail, need_access, done;
    logic          ll_done, link_clear;

    assign sc_fail     = datomic_in & memwrite_in & ~(link_valid & link_match);
    assign need_access = nRST & valid_in & (memread_in | (memwrite_in & ~sc_fail));
    assign done        = need_access & dhit;

    // A completed SC (necessarily successful) or any store to the linked word drops the link.
    assign ll_done    = done & memread_in & datomic_in;
    assign link_clear = done & memwrite_in & (datomic_in | link_match);

    link_reg u_link_reg (
        .CLK         (CLK),
        .nRST        (nRST),
        .set         (ll_done),
        .set_addr    (aluResult_in),
        .clear       (link_clear),
        .ccinv       (ccinv),
        .ccsnoopaddr (ccsnoopaddr),
        .cmp_addr    (aluResult_in),
        .link_valid  (link_valid),
        .match       (link_match)
    );

    assign dmemREN        = need_access & memread_in;
    assign dmemWEN        = need_access & memwrite_in;
    assign stall_out      = need_access & ~dhit;
    assign regwrite_out   = nRST & regwrite_in & valid_in & ~stall_out;

    assign dmemaddr       = nRST ? aluResult_in  : '0;
    assign dmemstore      = nRST ? storeData_in  : '0;
    assign memtoreg_out   = nRST ? memtoreg_in   : '0;
    assign branchDest_out = nRST ? branchDest_in : '0;
    assign npc_out        = nRST ? npc_in        : '0;
    assign aluResult_out  = nRST ? aluResult_in  : '0;
    assign upper16_out    = nRST ? upper16_in    : '0;

    always_comb begin
        dMemLoad_out = '0;
        if (nRST && valid_in) begin
            if (memread_in) begin
                dMemLoad_out = dmemload;
            end else if (memwrite_in && datomic_in) begin
                dMemLoad_out = {31'b0, ~sc_fail};
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (need_access && !dhit) next_state = WAIT;
            WAIT:    if (dhit)                 next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The watchdog only observes; the outstanding request keeps waiting for dhit.
    assign wd_next = (wd_cnt == WD_MAX) ? wd_cnt : wd_cnt + 1'b1;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wd_cnt      <= '0;
            mem_timeout <= 1'b0;
        end else if (state == WAIT) begin
            if (next_state == IDLE) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_next;
                if (wd_next == WD_MAX) begin
                    mem_timeout <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage MIPS pipeline, between the EX/MEM latch and the MEM/WB latch.
- Drives data-cache requests (dmemREN, dmemWEN) and waits on dhit.
- Freezes upstream stages while a request is outstanding and sends bubbles to MEM/WB until the access completes.
- Owns the LL/SC link register and a stall watchdog.

Parameters:
- TIMEOUT, 255: WAIT cycles before the sticky mem_timeout flag is set; must be ≥1.
- CW, $clog2(TIMEOUT+1): watchdog counter width (derived; do not override).

Ports:
- CLK  in  1  clock
- nRST  in  1  reset
- valid_in  in  1  EX/MEM slot holds a real instruction
- memread_in  in  1  load (LW, LL)
- memwrite_in  in  1  store (SW, SC)
- datomic_in  in  1  LL when memread_in=1; SC when memwrite_in=1
- aluResult_in  in  32  effective address / ALU result
- storeData_in  in  32  store data (rt)
- regwrite_in  in  1  writeback enable
- memtoreg_in  in  2  writeback mux select, passed through
- branchDest_in  in  5  destination register, passed through
- npc_in  in  32  PC+4, passed through
- upper16_in  in  32  LUI value, passed through
- dhit  in  1  cache completes request this cycle
- dmemload  in  32  cache read data, valid when dhit=1
- ccinv  in  1  coherence invalidate strobe
- ccsnoopaddr  in  32  invalidated address
- dmemREN  out  1  cache read request
- dmemWEN  out  1  cache write request
- dmemaddr  out  32  cache address
- dmemstore  out  32  cache write data
- stall_out  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- regwrite_out  out  1  to MEM/WB
- memtoreg_out  out  2  to MEM/WB
- branchDest_out  out  5  to MEM/WB
- npc_out  out  32  to MEM/WB
- aluResult_out  out  32  to MEM/WB
- upper16_out  out  32  to MEM/WB
- dMemLoad_out  out  32  to MEM/WB
- mem_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset: nRST is asynchronous, active-low; clock is CLK. While nRST=0:
  - state=IDLE, link_valid=0, link_addr=0, wd_cnt=0, mem_timeout=0.
  - dmemREN, dmemWEN, stall_out and regwrite_out are forced 0.
  - All other outputs are 0.
- Reset mid-request: the request drops immediately; no writeback is produced.
- Definitions:
  - need_access = valid_in & (memread_in | (memwrite_in & ~sc_fail)).
  - sc_fail = datomic_in & memwrite_in & ~(link_valid & link_addr==aluResult_in).
- Request outputs (combinational):
  - dmemREN = need_access & memread_in.
  - dmemWEN = need_access & memwrite_in.
  - dmemaddr = aluResult_in; dmemstore = storeData_in.
  - Requests stay asserted and stable until dhit. Inputs are guaranteed stable while stall_out=1.
- stall_out = need_access & ~dhit.
  - Zero-wait hit: completes in the same cycle with no stall.
- FSM with states IDLE and WAIT (used for watchdog and verification observability):
  - IDLE → WAIT when need_access & ~dhit.
  - WAIT → IDLE on dhit.
- Watchdog:
  - In WAIT, wd_cnt increments and saturates at TIMEOUT. It clears on the transition to IDLE.
  - mem_timeout sets when wd_cnt==TIMEOUT and holds until reset.
  - The request is not aborted.
- Writeback gating:
  - regwrite_out = regwrite_in & valid_in & ~stall_out, so every stalled cycle sends a bubble.
  - Pass-through outputs copy their inputs.
- dMemLoad_out:
  - Loads: dmemload.
  - SC: {31'b0, sc_success}, where sc_success = ~sc_fail and the SC register write carries 1 or 0.
  - Otherwise: 0.
- Failed SC: no cache request, no stall, completes in the same cycle, and rt receives 0.
- Link register, updated on the clock edge:
  - LL completes (dhit): link_valid=1, link_addr=aluResult_in.
  - SC success completes: link_valid=0.
  - SW/SC completes at link_addr: link_valid=0.
  - ccinv & ccsnoopaddr==link_addr: link_valid=0.
  - Priority: clear beats set. An invalidate in the same cycle as an LL completing to the same address leaves link_valid=0.
- Address comparisons use the word address, bits 31:2.

Decomposition:
- cpu_types_pkg additions:
  - word_t (32 bits).
  - regbits_t (5 bits).
  - memstate_t enum {IDLE, WAIT}.
  - WORD_ADDR_LSB=2.
- Sub-module link_reg: holds link_valid/link_addr and applies set/clear priority. It exposes a combinational match output.
- The FSM and watchdog stay inline.

Test Plan:
- LW to 0x100 with dhit after 3 cycles, dmemload=0xDEADBEEF:
  - dmemREN=1 for 4 cycles; stall_out=1 and regwrite_out=0 for 3 cycles.
  - Completion cycle: regwrite_out=1, dMemLoad_out=0xDEADBEEF, state returns to IDLE.
- SW to 0x200 with data 0x12345678 and same-cycle dhit:
  - dmemWEN=1, dmemstore=0x12345678, stall_out never asserted.
- LL to 0x300 then SC to 0x300:
  - SC issues dmemWEN and returns dMemLoad_out=1; link_valid=0 afterwards.
  - A second SC to 0x300 has no request and returns 0.
- LL to 0x300, then ccinv with ccsnoopaddr=0x300, then SC to 0x300:
  - The SC fails with no dmemWEN and dMemLoad_out=0.
  - Also cover ccinv in the LL completion cycle: link_valid ends 0.
- TIMEOUT=4, LW with dhit withheld for 10 cycles:
  - mem_timeout rises after the 4th WAIT cycle and stays 1 after dhit.
  - Cleared only by nRST.
- nRST pulsed low during WAIT:
  - dmemREN, stall_out and regwrite_out drop asynchronously.
  - state=IDLE, link_valid=0, mem_timeout=0.
